// File: rtl/icache_refill_if.sv
// rtl/icache_refill_if.sv - miss, memory-bus and SRAM-write signal bundle for icache_refill
interface icache_refill_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 128,
  parameter int N_WAY      = 4
);
  logic                  i_cache_miss;
  logic [31:0]           i_addr_miss;
  logic [N_WAY-1:0]      i_vic_miss;
  logic                  o_resp_miss;
  logic                  o_mem_req;
  logic [31:0]           o_mem_addr;
  logic                  i_mem_gnt;
  logic                  i_mem_rvalid;
  logic [31:0]           i_mem_rdata;
  logic                  o_tag_wren;
  logic [ADDR_WIDTH-1:0] o_tag_waddr;
  logic [TAG_WIDTH-1:0]  o_tag_wdata;
  logic [N_WAY-1:0]      o_way_wren;
  logic [DATA_WIDTH-1:0] o_data_wdata;
  logic                  o_init_done;

  modport master (
    output i_cache_miss, i_addr_miss, i_vic_miss, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    input  o_resp_miss, o_mem_req, o_mem_addr, o_tag_wren, o_tag_waddr, o_tag_wdata,
           o_way_wren, o_data_wdata, o_init_done
  );

  modport slave (
    input  i_cache_miss, i_addr_miss, i_vic_miss, i_mem_gnt, i_mem_rvalid, i_mem_rdata,
    output o_resp_miss, o_mem_req, o_mem_addr, o_tag_wren, o_tag_waddr, o_tag_wdata,
           o_way_wren, o_data_wdata, o_init_done
  );
endinterface

// File: rtl/icache_refill.sv
// rtl/icache_refill.sv - instruction-cache line refill engine with post-reset tag invalidate sweep
// Optional ICACHE_RR_VICTIM_EN: per-set round-robin victim pointer replaces i_vic_miss.
module icache_refill #(
  parameter int ADDR_WIDTH = 6,
  parameter int TAG_WIDTH  = 8,
  parameter int DATA_WIDTH = 128,
  parameter int N_WAY      = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  icache_refill_if.slave bus
);
  localparam int WORDS = DATA_WIDTH / 32;
  localparam int CW    = $clog2(WORDS) + 1;
  localparam int SETS  = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_WRITE, S_RESP} state_t;
  state_t state, state_n;

  logic [ADDR_WIDTH-1:0] init_cnt, init_cnt_n;
  logic                  init_done, init_done_n;
  logic                  pending, pending_n;
  logic [29:0]           addr_q, addr_n;
  logic [CW-1:0]         issue_cnt, issue_n;
  logic [CW-1:0]         rcnt, rcnt_n;
  logic [DATA_WIDTH-1:0] line_q, line_n;

  logic                  resp_q, resp_n;
  logic                  mem_req_q, mem_req_n;
  logic [31:0]           mem_addr_q, mem_addr_n;
  logic                  tag_wren_q, tag_wren_n;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_n;
  logic [TAG_WIDTH-1:0]  tag_wdata_q, tag_wdata_n;
  logic [N_WAY-1:0]      way_wren_q, way_wren_n;
  logic [DATA_WIDTH-1:0] data_wdata_q, data_wdata_n;

  logic [ADDR_WIDTH-1:0] idx_q;
  logic [TAG_WIDTH-2:0]  tag_q;
  logic [31:0]           base_q;
  logic [N_WAY-1:0]      victim;

  // Latched address keeps only the word-line part; the low two bits never matter.
  assign idx_q  = addr_q[0 +: ADDR_WIDTH];
  assign tag_q  = addr_q[ADDR_WIDTH +: TAG_WIDTH-1];
  assign base_q = {addr_q, 2'b00};

`ifdef ICACHE_RR_VICTIM_EN
  localparam int PW = (N_WAY > 1) ? $clog2(N_WAY) : 1;
  logic [PW-1:0] rr_ptr [SETS];

  assign victim = N_WAY'(1) << rr_ptr[idx_q];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else if (state == S_INIT) begin
      rr_ptr[init_cnt] <= '0;
    end else if (state == S_WRITE) begin
      rr_ptr[idx_q] <= (rr_ptr[idx_q] == PW'(N_WAY-1)) ? '0 : rr_ptr[idx_q] + PW'(1);
    end
  end
`else
  logic [N_WAY-1:0] vic_q, vic_n;
  logic             vic_onehot;
  logic [N_WAY-1:0] vic_sel;

  // A corrupt (non-one-hot) hint from the search stage falls back to way 0.
  assign vic_onehot = (bus.i_vic_miss != '0) &&
                      ((bus.i_vic_miss & (bus.i_vic_miss - 1'b1)) == '0);
  assign vic_sel    = vic_onehot ? bus.i_vic_miss : N_WAY'(1);
  assign victim     = vic_q;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_INIT;
    else          state <= state_n;
  end

  // Outputs are computed one step ahead and registered so they are all zero in reset.
  always_comb begin
    state_n      = state;
    init_cnt_n   = init_cnt;
    init_done_n  = init_done;
    pending_n    = pending;
    addr_n       = addr_q;
    issue_n      = issue_cnt;
    rcnt_n       = rcnt;
    line_n       = line_q;
    resp_n       = 1'b0;
    mem_req_n    = 1'b0;
    mem_addr_n   = '0;
    tag_wren_n   = 1'b0;
    waddr_n      = '0;
    tag_wdata_n  = '0;
    way_wren_n   = '0;
    data_wdata_n = '0;
`ifndef ICACHE_RR_VICTIM_EN
    vic_n        = vic_q;
`endif
    case (state)
      S_INIT: begin
        tag_wren_n = 1'b1;
        way_wren_n = '1;
        waddr_n    = init_cnt;
        init_cnt_n = init_cnt + 1'b1;
        if (bus.i_cache_miss && !pending) begin
          pending_n = 1'b1;
          addr_n    = bus.i_addr_miss[31:2];
`ifndef ICACHE_RR_VICTIM_EN
          vic_n     = vic_sel;
`endif
        end
        if (init_cnt == ADDR_WIDTH'(SETS-1)) state_n = S_IDLE;
      end
      S_IDLE: begin
        init_done_n = 1'b1;
        if (bus.i_cache_miss || pending) begin
          if (!pending) begin
            addr_n = bus.i_addr_miss[31:2];
`ifndef ICACHE_RR_VICTIM_EN
            vic_n  = vic_sel;
`endif
          end
          pending_n  = 1'b0;
          issue_n    = '0;
          rcnt_n     = '0;
          mem_req_n  = 1'b1;
          mem_addr_n = {addr_n, 2'b00};
          state_n    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_req_q && bus.i_mem_gnt) issue_n = issue_cnt + 1'b1;
        // Only responses to already-granted requests are accepted.
        if (bus.i_mem_rvalid && (rcnt != issue_cnt)) begin
          line_n[32*rcnt[CW-2:0] +: 32] = bus.i_mem_rdata;
          rcnt_n = rcnt + 1'b1;
        end
        mem_req_n = (issue_n < CW'(WORDS));
        if (mem_req_n) mem_addr_n = base_q + 32'(issue_n);
        if (rcnt_n == CW'(WORDS)) begin
          state_n      = S_WRITE;
          tag_wren_n   = 1'b1;
          way_wren_n   = victim;
          waddr_n      = idx_q;
          tag_wdata_n  = {1'b1, tag_q};
          data_wdata_n = line_n;
        end
      end
      S_WRITE: begin
        resp_n  = 1'b1;
        state_n = S_RESP;
      end
      S_RESP: state_n = S_IDLE;
      default: state_n = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      init_cnt     <= '0;
      init_done    <= 1'b0;
      pending      <= 1'b0;
      addr_q       <= '0;
      issue_cnt    <= '0;
      rcnt         <= '0;
      line_q       <= '0;
      resp_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      tag_wren_q   <= 1'b0;
      waddr_q      <= '0;
      tag_wdata_q  <= '0;
      way_wren_q   <= '0;
      data_wdata_q <= '0;
`ifndef ICACHE_RR_VICTIM_EN
      vic_q        <= '0;
`endif
    end else begin
      init_cnt     <= init_cnt_n;
      init_done    <= init_done_n;
      pending      <= pending_n;
      addr_q       <= addr_n;
      issue_cnt    <= issue_n;
      rcnt         <= rcnt_n;
      line_q       <= line_n;
      resp_q       <= resp_n;
      mem_req_q    <= mem_req_n;
      mem_addr_q   <= mem_addr_n;
      tag_wren_q   <= tag_wren_n;
      waddr_q      <= waddr_n;
      tag_wdata_q  <= tag_wdata_n;
      way_wren_q   <= way_wren_n;
      data_wdata_q <= data_wdata_n;
`ifndef ICACHE_RR_VICTIM_EN
      vic_q        <= vic_n;
`endif
    end
  end

  assign bus.o_resp_miss  = resp_q;
  assign bus.o_mem_req    = mem_req_q;
  assign bus.o_mem_addr   = mem_addr_q;
  assign bus.o_tag_wren   = tag_wren_q;
  assign bus.o_tag_waddr  = waddr_q;
  assign bus.o_tag_wdata  = tag_wdata_q;
  assign bus.o_way_wren   = way_wren_q;
  assign bus.o_data_wdata = data_wdata_q;
  assign bus.o_init_done  = init_done;
endmodule

// File: tb/tb_icache_refill.sv
// tb/tb_icache_refill.sv - scoreboard testbench for icache_refill (models ICACHE_RR_VICTIM_EN when defined)
module tb_icache_refill;
  localparam int AW = 6;
  localparam int TW = 8;
  localparam int DW = 128;
  localparam int NW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_refill_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .N_WAY(NW)) bus ();

  icache_refill #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .N_WAY(NW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [AW-1:0] waddr;
    logic [TW-1:0] tag;
    logic [NW-1:0] way;
    logic [DW-1:0] data;
  } wr_t;

  wr_t         exp_wr_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] rsp_q[$];
  int checks = 0;
  int failures = 0;
  int resp_cnt = 0;
  int rv_cnt = 0;
  int hold = 0;
  int stall_seen = 0;
  bit stray = 0;
  bit prev_wr = 0;
  logic [1:0] rr_model [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (((a & ~32'h3) ^ 32'h1234) << 8) | 32'hA0 | {30'd0, a[1:0]};
  endfunction

  // Memory: grants in the same cycle as the request unless stalled, answers one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_q.delete();
      bus.i_mem_rvalid = 1'b0;
      bus.i_mem_gnt    = 1'b0;
      bus.i_mem_rdata  = 32'h0;
    end else begin
      if (rsp_q.size() > 0) begin
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = rsp_q.pop_front();
        rv_cnt++;
      end else if (stray && bus.o_mem_req && hold > 0) begin
        bus.i_mem_rvalid = 1'b1;
        bus.i_mem_rdata  = 32'hBAD0_BAD0;
        stray = 0;
      end else begin
        bus.i_mem_rvalid = 1'b0;
        bus.i_mem_rdata  = 32'hDEAD_BEEF;
      end
      bus.i_mem_gnt = 1'b0;
      if (bus.o_mem_req) begin
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL mem_req_unexpected got addr=%h need no request", bus.o_mem_addr);
        end else begin
          if (bus.o_mem_addr !== exp_addr_q[0]) begin
            failures++;
            $display("FAIL mem_addr got=%h need=%h", bus.o_mem_addr, exp_addr_q[0]);
          end
          if (hold > 0) begin
            hold--;
            stall_seen++;
          end else begin
            bus.i_mem_gnt = 1'b1;
            rsp_q.push_back(mem_word(bus.o_mem_addr));
            void'(exp_addr_q.pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    wr_t w;
    if (rst_n && bus.o_resp_miss === 1'b1) begin
      resp_cnt++;
      checks++;
      if (!prev_wr) begin
        failures++;
        $display("FAIL resp_after_write got no refill write in previous cycle need one");
      end
    end
    prev_wr = 0;
    if (rst_n && bus.o_tag_wren === 1'b1 && bus.o_way_wren !== 4'hF) begin
      prev_wr = 1;
      checks++;
      if (exp_wr_q.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected got way=%b waddr=%h need no write", bus.o_way_wren, bus.o_tag_waddr);
      end else begin
        w = exp_wr_q.pop_front();
        checks += 3;
        if (bus.o_tag_waddr !== w.waddr) begin
          failures++;
          $display("FAIL wr_waddr got=%h need=%h", bus.o_tag_waddr, w.waddr);
        end
        if (bus.o_tag_wdata !== w.tag) begin
          failures++;
          $display("FAIL wr_tag got=%h need=%h", bus.o_tag_wdata, w.tag);
        end
        if (bus.o_way_wren !== w.way) begin
          failures++;
          $display("FAIL wr_way got=%b need=%b", bus.o_way_wren, w.way);
        end
        if (bus.o_data_wdata !== w.data) begin
          failures++;
          $display("FAIL wr_data got=%h need=%h", bus.o_data_wdata, w.data);
        end
      end
    end
  end

  task automatic issue_miss(input logic [31:0] a, input logic [NW-1:0] vic);
    wr_t w;
    logic [31:0] base;
    logic [AW-1:0] idx;
    base = {a[31:2], 2'b00};
    idx  = a[2 +: AW];
    for (int k = 0; k < 4; k++) exp_addr_q.push_back(base + 32'(k));
    w.waddr = idx;
    w.tag   = {1'b1, a[2+AW +: TW-1]};
`ifdef ICACHE_RR_VICTIM_EN
    w.way = NW'(1) << rr_model[idx];
    rr_model[idx] = rr_model[idx] + 2'd1;
`else
    w.way = ($countones(vic) == 1) ? vic : NW'(1);
`endif
    w.data = {mem_word(base + 32'd3), mem_word(base + 32'd2), mem_word(base + 32'd1), mem_word(base)};
    exp_wr_q.push_back(w);
    bus.i_cache_miss = 1'b1;
    bus.i_addr_miss  = a;
    bus.i_vic_miss   = vic;
    @(negedge clk);
    bus.i_cache_miss = 1'b0;
  endtask

  task automatic wait_resp(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_resp_miss === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_init(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_init_done === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.i_cache_miss = 1'b0;
    hold = 0;
    stray = 0;
    for (int i = 0; i < 64; i++) rr_model[i] = 2'd0;
    repeat (3) @(negedge clk);
    exp_addr_q.delete();
    exp_wr_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.i_cache_miss = 1'b0;
    bus.i_addr_miss  = 32'h0;
    bus.i_vic_miss   = '0;
    for (int i = 0; i < 64; i++) rr_model[i] = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_tag_wren, bus.o_way_wren, bus.o_mem_req, bus.o_resp_miss, bus.o_init_done} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b need=00000000",
               {bus.o_tag_wren, bus.o_way_wren, bus.o_mem_req, bus.o_resp_miss, bus.o_init_done});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.o_tag_wren, bus.o_tag_waddr, bus.o_way_wren, bus.o_init_done} !== {1'b1, 6'(k), 4'hF, 1'b0}) begin
        failures++;
        $display("FAIL init_sweep_%0d got wren=%b waddr=%h way=%b done=%b need 1 %h 1111 0",
                 k, bus.o_tag_wren, bus.o_tag_waddr, bus.o_way_wren, bus.o_init_done, 6'(k));
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.o_init_done, bus.o_tag_wren} !== 2'b10) begin
      failures++;
      $display("FAIL init_done got done=%b wren=%b need done=1 wren=0", bus.o_init_done, bus.o_tag_wren);
    end
  endtask

  task automatic test_basic();
    bit ok;
    int r0;
    r0 = resp_cnt;
    issue_miss(32'h0000_1236, 4'b0100);
    wait_resp(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_resp_timeout got none need resp"); end
    @(negedge clk);
    checks++;
    if (resp_cnt != r0 + 1) begin failures++; $display("FAIL basic_resp_count got=%0d need=%0d", resp_cnt - r0, 1); end
    checks++;
    if (bus.o_resp_miss !== 1'b0) begin failures++; $display("FAIL basic_resp_width got=%b need=0", bus.o_resp_miss); end
    checks++;
    if (exp_wr_q.size() + exp_addr_q.size() != 0) begin
      failures++;
      $display("FAIL basic_drain got=%0d need=0", exp_wr_q.size() + exp_addr_q.size());
    end
  endtask

  task automatic test_gnt_stall();
    bit ok;
    stall_seen = 0;
    hold = 5;
    stray = 1;
    issue_miss(32'h0000_1236, 4'b1000);
    wait_resp(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL stall_resp_timeout got none need resp"); end
    @(negedge clk);
    checks++;
    if (stall_seen != 5) begin failures++; $display("FAIL stall_cycles got=%0d need=5", stall_seen); end
    checks++;
    if (exp_wr_q.size() != 0) begin failures++; $display("FAIL stall_drain got=%0d need=0", exp_wr_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0;
    logic [31:0] addrs [3];
    logic [NW-1:0] vics [3];
    addrs[0] = 32'h0000_2238; vics[0] = 4'b0010;
    addrs[1] = 32'h00AB_CDEF; vics[1] = 4'b0110;
    addrs[2] = 32'hFFFF_FFFC; vics[2] = 4'b0000;
    r0 = resp_cnt;
    for (int i = 0; i < 3; i++) begin
      issue_miss(addrs[i], vics[i]);
      checks++;
      if (bus.o_mem_req !== 1'b1) begin failures++; $display("FAIL b2b_req_latency_%0d got=%b need=1", i, bus.o_mem_req); end
      wait_resp(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_resp_timeout_%0d got none need resp", i); end
      @(negedge clk);
    end
    checks++;
    if (resp_cnt != r0 + 3) begin failures++; $display("FAIL b2b_resp_count got=%0d need=3", resp_cnt - r0); end
  endtask

  task automatic test_abort();
    bit ok;
    int r0;
    int v0;
    r0 = resp_cnt;
    v0 = rv_cnt;
    issue_miss(32'h0000_4440, 4'b0001);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      if (rv_cnt - v0 >= 2) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_rvalid_timeout got=%0d need=2", rv_cnt - v0); end
    #1;
    rst_n = 1'b0;
    exp_addr_q.delete();
    exp_wr_q.delete();
    for (int i = 0; i < 64; i++) rr_model[i] = 2'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_tag_wren, bus.o_resp_miss, bus.o_mem_req, bus.o_init_done} !== 4'b0000) begin
      failures++;
      $display("FAIL abort_reset_outputs got=%b need=0000", {bus.o_tag_wren, bus.o_resp_miss, bus.o_mem_req, bus.o_init_done});
    end
    exp_addr_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_tag_wren, bus.o_tag_waddr, bus.o_way_wren} !== {1'b1, 6'h00, 4'hF}) begin
      failures++;
      $display("FAIL abort_sweep_restart got wren=%b waddr=%h way=%b need 1 00 1111",
               bus.o_tag_wren, bus.o_tag_waddr, bus.o_way_wren);
    end
    wait_init(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL abort_init_timeout got none need init_done"); end
    repeat (4) @(negedge clk);
    checks++;
    if (resp_cnt != r0) begin failures++; $display("FAIL abort_no_resp got=%0d need=0", resp_cnt - r0); end
  endtask

  task automatic test_init_pending();
    bit ok;
    int r0;
    do_reset();
    r0 = resp_cnt;
    repeat (10) @(negedge clk);
    issue_miss(32'h0000_0880, 4'b0010);
    repeat (5) @(negedge clk);
    bus.i_cache_miss = 1'b1;
    bus.i_addr_miss  = 32'h0000_0CC0;
    bus.i_vic_miss   = 4'b1000;
    @(negedge clk);
    bus.i_cache_miss = 1'b0;
    wait_init(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pend_init_timeout got none need init_done"); end
    checks++;
    if (bus.o_mem_req !== 1'b1) begin failures++; $display("FAIL pend_served_at_init_done got req=%b need=1", bus.o_mem_req); end
    wait_resp(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pend_resp_timeout got none need resp"); end
    repeat (12) @(negedge clk);
    checks++;
    if (resp_cnt != r0 + 1) begin failures++; $display("FAIL pend_resp_count got=%0d need=1", resp_cnt - r0); end
  endtask

  task automatic test_victim();
    bit ok;
    int r0;
    logic [31:0] addrs [6];
    logic [NW-1:0] vics [6];
    addrs[0] = 32'h0000_1234; vics[0] = 4'b1000;
    addrs[1] = 32'h0000_5634; vics[1] = 4'b0001;
    addrs[2] = 32'h0000_0038; vics[2] = 4'b0100;
    addrs[3] = 32'h0000_9A35; vics[3] = 4'b0010;
    addrs[4] = 32'h0000_7734; vics[4] = 4'b1100;
    addrs[5] = 32'h0000_0134; vics[5] = 4'b0100;
    do_reset();
    wait_init(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL victim_init_timeout got none need init_done"); end
    r0 = resp_cnt;
    for (int i = 0; i < 6; i++) begin
      issue_miss(addrs[i], vics[i]);
      wait_resp(ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL victim_resp_timeout_%0d got none need resp", i); end
      @(negedge clk);
    end
    checks++;
    if (resp_cnt != r0 + 6 || exp_wr_q.size() != 0) begin
      failures++;
      $display("FAIL victim_drain got resp=%0d left=%0d need resp=6 left=0", resp_cnt - r0, exp_wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gnt_stall();
    test_back_to_back();
    test_abort();
    test_init_pending();
    test_victim();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout need completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Miss-service engine on the far side of the instruction-cache search stage.
- Accepts a one-cycle miss pulse (word address plus victim-way hint) and fetches the 4-word line from the instruction memory over a req/gnt/rvalid word bus.
- Writes the tag and data SRAMs of the victim way, then pulses the miss response back to the search stage.
- After reset it also sweeps every set and invalidates all tags.

Parameters:
- ADDR_WIDTH, 6: set-index width; 2^ADDR_WIDTH sets.
- TAG_WIDTH, 8: tag entry width; MSB = valid, low TAG_WIDTH-1 bits = address tag.
- DATA_WIDTH, 128: line width; WORDS = DATA_WIDTH/32 = 4.
- N_WAY, 4: number of ways.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_cache_miss, in, 1: one-cycle miss pulse from the search stage.
- i_addr_miss, in, 32: missing word address.
- i_vic_miss, in, N_WAY: one-hot victim way.
- o_resp_miss, out, 1: one-cycle refill-complete pulse.
- o_mem_req, out, 1: memory read request.
- o_mem_addr, out, 32: word address of the request.
- i_mem_gnt, in, 1: request accepted.
- i_mem_rvalid, in, 1: read data valid.
- i_mem_rdata, in, 32: read data.
- o_tag_wren, out, 1: tag/data SRAM write strobe.
- o_tag_waddr, out, ADDR_WIDTH: set index for the write.
- o_tag_wdata, out, TAG_WIDTH: tag written.
- o_way_wren, out, N_WAY: per-way write enable.
- o_data_wdata, out, DATA_WIDTH: line written.
- o_init_done, out, 1: high once the invalidate sweep has finished.

Behaviour:
- Addresses are word addresses.
  - index = addr[2+:ADDR_WIDTH].
  - tag = addr[2+ADDR_WIDTH+:TAG_WIDTH-1].
  - line base = {addr[31:2],2'b00}.
- Reset values:
  - All outputs 0.
  - State = INIT, init counter = 0.
  - Latched address and way = 0.
  - Line buffer = 0.
- INIT state:
  - Each cycle: o_tag_wren=1, o_way_wren=all ones, o_tag_wdata=0, o_data_wdata=0, o_tag_waddr=counter; counter increments.
  - After set 2^ADDR_WIDTH-1 is written, go to IDLE and set o_init_done=1. o_init_done stays 1 until reset.
  - The sweep takes exactly 2^ADDR_WIDTH cycles.
  - A miss pulse during INIT is latched (one-deep pending flag) and served on entry to IDLE. Further pulses during INIT are dropped.
- IDLE state:
  - On i_cache_miss (or the pending flag), latch i_addr_miss and i_vic_miss, clear the issue and receive counters, go to FETCH.
  - If the latched victim is not one-hot, use way 0.
- FETCH state:
  - o_mem_req=1 while issue count < WORDS; o_mem_addr = line base + issue count.
  - Request and address are held stable until i_mem_gnt; each grant increments the issue count. Back-to-back grants are allowed (pipelined).
  - Each i_mem_rvalid stores i_mem_rdata into line slice [32*rcnt+:32] and increments rcnt. Responses arrive in order, at least 1 cycle after their grant.
  - When rcnt reaches WORDS, go to WRITE.
  - rvalid with no request outstanding is ignored.
- WRITE state, one cycle:
  - o_tag_wren=1.
  - o_way_wren = latched victim.
  - o_tag_waddr = index.
  - o_tag_wdata = {1'b1, tag}.
  - o_data_wdata = line buffer.
  - Next state RESP.
- RESP state, one cycle:
  - o_resp_miss=1 (the write is already visible to the SRAM), then IDLE.
  - A new miss may be accepted on the first IDLE cycle.
- Outside INIT and WRITE, o_tag_wren and o_way_wren are 0.
- i_cache_miss outside IDLE/INIT is dropped; the search stage holds its grant low, so this is illegal stimulus.
- Minimum miss-to-response latency: 1 (latch) + WORDS+1 (zero-wait memory) + 1 (WRITE) + 1 (RESP).
- Reset asserted mid-refill: abort immediately, no SRAM write, no o_resp_miss, restart INIT.

Optional Feature:
- Macro ICACHE_RR_VICTIM_EN.
- Defined:
  - i_vic_miss is ignored.
  - A per-set round-robin pointer (log2 N_WAY bits per set, reset to 0) selects the victim.
  - The pointer advances by 1 (wrapping N_WAY-1 to 0) in the WRITE cycle of that set only.
  - INIT resets all pointers to 0.
- Undefined: the victim is the latched i_vic_miss (non-one-hot falls back to way 0); no pointer storage.

Test Plan:
- Reset release, no stimulus -> o_tag_wren high for 64 cycles with o_tag_waddr 0..63, o_way_wren=4'hF; o_init_done=1 on cycle 65; no o_mem_req.
- After init, miss addr 0x00001236, vic 4'b0100, zero-wait memory returning 0xA0..0xA3 -> requests at 0x1234..0x1237; then WRITE with waddr 0x0D, tag_wdata 0x92, way_wren 4'b0100, data_wdata 0x000000A3_000000A2_000000A1_000000A0; o_resp_miss the next cycle.
- i_mem_gnt held low 5 cycles on the first request -> o_mem_req/o_mem_addr stable at 0x1234 throughout; line contents are still correct.
- Miss pulsed at cycle 10 of INIT -> served immediately after o_init_done rises; exactly one o_resp_miss.
- Reset asserted after the 2nd rvalid -> no o_tag_wren with victim enables, no o_resp_miss; INIT sweep restarts from set 0.
- ICACHE_RR_VICTIM_EN defined, 5 misses to set 0x0D -> victim ways 0,1,2,3,0; a miss to set 0x0E in between uses way 0.
